// File: rtl/gpio_led_ctrl_if.sv
// gpio_led_ctrl_if: register bus between the core data port and the LED controller.
//   sel    - access request, sampled only while the controller is idle
//   mem_wr - 1 = write, 0 = read
//   addr   - byte address; [3:2] selects the register, [10:4] must be 0 when checked
//   din    - write data
//   dout   - read data, held until the next read completes
//   busy   - high for the single cycle an access is being acknowledged
interface gpio_led_ctrl_if;
    logic        sel;
    logic        mem_wr;
    logic [10:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;

    modport master (output sel, output mem_wr, output addr, output din,
                    input dout, input busy);
    modport slave  (input sel, input mem_wr, input addr, input din,
                    output dout, output busy);
endinterface

// File: rtl/gpio_led_ctrl.sv
// gpio_led_ctrl: four-LED output controller with ODR, per-LED 8-bit PWM and optional blink.
//   clock    - system clock, rising edge
//   rst      - asynchronous active-low reset
//   bus      - register bus (slave side), see gpio_led_ctrl_if
//   out_leds - registered LED drive
// Register map: 0x0 ODR[3:0], 0x4 DUTY (8 bits per LED), 0x8 CTRL ([3:0] PWM en,
// [7:4] blink en), 0xC PRESCALE[15:0]. Unused bits read 0.
// Build option: define GPIO_LED_BLINK_EN to include the blink phase and CTRL[7:4].
module gpio_led_ctrl #(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter int unsigned BASE_CHK     = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    gpio_led_ctrl_if.slave        bus,
    output logic [3:0]            out_leds
);

    typedef enum logic {StIdle, StAck} state_e;

    state_e      state_q, state_d;
    logic [1:0]  reg_q;
    logic        mapped_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [31:0] dout_q;

    logic [3:0]  odr_q;
    logic [31:0] duty_q;
    logic [3:0]  pwm_en_q;
    logic [15:0] prescale_q;
    logic [15:0] pcnt_q;
    logic [7:0]  pwm_cnt_q;
    logic [3:0]  leds_q;
`ifdef GPIO_LED_BLINK_EN
    logic [3:0]  blink_en_q;
    logic        blink_q;
`endif

    logic        req_mapped;
    logic        commit;
    logic        wr_en;
    logic        tick;
    logic [31:0] rdata;
    logic [3:0]  leds_d;

    assign req_mapped = (BASE_CHK == 0) || (bus.addr[10:4] == 7'd0);
    // ACK always lasts exactly one cycle, so the edge leaving ACK is the commit edge.
    assign commit     = (state_q == StAck);
    assign wr_en      = commit && wr_q && mapped_q;
    assign tick       = (pcnt_q == prescale_q);

    assign bus.busy   = (state_q == StAck);
    assign bus.dout   = dout_q;
    assign out_leds   = leds_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.sel) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            reg_q    <= 2'd0;
            mapped_q <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.sel) begin
                reg_q    <= bus.addr[3:2];
                mapped_q <= req_mapped;
                wr_q     <= bus.mem_wr;
                wdata_q  <= bus.din;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (mapped_q) begin
            unique case (reg_q)
                2'd0: rdata[3:0] = odr_q;
                2'd1: rdata      = duty_q;
                2'd2: begin
                    rdata[3:0] = pwm_en_q;
`ifdef GPIO_LED_BLINK_EN
                    rdata[7:4] = blink_en_q;
`endif
                end
                2'd3: rdata[15:0] = prescale_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            odr_q      <= 4'd0;
            duty_q     <= 32'd0;
            pwm_en_q   <= 4'd0;
            prescale_q <= PRESCALE_RST;
            dout_q     <= 32'd0;
`ifdef GPIO_LED_BLINK_EN
            blink_en_q <= 4'd0;
`endif
        end else begin
            if (commit && !wr_q) dout_q <= rdata;
            if (wr_en) begin
                unique case (reg_q)
                    2'd0: odr_q  <= wdata_q[3:0];
                    2'd1: duty_q <= wdata_q;
                    2'd2: begin
                        pwm_en_q <= wdata_q[3:0];
`ifdef GPIO_LED_BLINK_EN
                        blink_en_q <= wdata_q[7:4];
`endif
                    end
                    2'd3: prescale_q <= wdata_q[15:0];
                    default: ;
                endcase
            end
        end
    end

    // A PRESCALE write restarts the prescaler so the new period starts cleanly.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            pcnt_q    <= 16'd0;
            pwm_cnt_q <= 8'd0;
`ifdef GPIO_LED_BLINK_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            if (wr_en && reg_q == 2'd3) begin
                pcnt_q <= 16'd0;
            end else if (tick) begin
                pcnt_q <= 16'd0;
            end else begin
                pcnt_q <= pcnt_q + 16'd1;
            end
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + 8'd1;
`ifdef GPIO_LED_BLINK_EN
                if (pwm_cnt_q == 8'hFF) blink_q <= ~blink_q;
`endif
            end
        end
    end

    always_comb begin
        leds_d = odr_q;
        for (int i = 0; i < 4; i++) begin
            if (pwm_en_q[i]) begin
                leds_d[i] = (pwm_cnt_q < duty_q[8*i +: 8]);
`ifdef GPIO_LED_BLINK_EN
            end else if (blink_en_q[i]) begin
                leds_d[i] = odr_q[i] & blink_q;
`endif
            end else begin
                leds_d[i] = odr_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) leds_q <= 4'd0;
        else      leds_q <= leds_d;
    end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// tb_gpio_led_ctrl: self-checking bench for gpio_led_ctrl. Read expectations are pushed to a
// scoreboard queue when the read is issued and popped when dout is valid.
module tb_gpio_led_ctrl;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] out_leds;

    gpio_led_ctrl_if bus ();

    gpio_led_ctrl #(
        .PRESCALE_RST (16'h0123),
        .BASE_CHK     (1)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .bus      (bus),
        .out_leds (out_leds)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    // One bus access starting at the next falling edge; returns busy in ACK and after commit.
    task automatic access(input logic wr, input logic [10:0] a, input logic [31:0] d,
                          output logic busy_ack, output logic busy_done);
        @(negedge clock);
        bus.sel    = 1'b1;
        bus.mem_wr = wr;
        bus.addr   = a;
        bus.din    = d;
        @(posedge clock); #1;
        busy_ack = bus.busy;
        bus.sel  = 1'b0;
        @(posedge clock); #1;
        busy_done = bus.busy;
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        bus.sel = 1'b0; bus.mem_wr = 1'b0; bus.addr = 11'd0; bus.din = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.dout !== 32'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
        checks++; if (out_leds !== 4'd0) begin errors++; $display("FAIL reset_leds got=%b exp=0", out_leds); end
        // First request presented together with reset release must be taken on the next edge.
        @(negedge clock);
        rst = 1'b1;
        bus.sel = 1'b1; bus.mem_wr = 1'b0; bus.addr = 11'h00C;
        exp_q.push_back(32'h0000_0123);
        @(posedge clock); #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_req_busy got=%b exp=1", bus.busy); end
        bus.sel = 1'b0;
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL reset_prescale got=%h exp=%h", bus.dout, exp); end
    endtask

    task automatic test_odr_rw;
        logic        b1, b2;
        logic [31:0] exp;
        access(1'b1, 11'h000, 32'h0000_000A, b1, b2);
        checks++; if (b1 !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL odr_wr_busy got=%b%b exp=10", b1, b2); end
        checks++; if (out_leds !== 4'b0000) begin errors++; $display("FAIL odr_early got=%b exp=0000", out_leds); end
        @(posedge clock); #1;
        checks++; if (out_leds !== 4'b1010) begin errors++; $display("FAIL odr_leds got=%b exp=1010", out_leds); end
        exp_q.push_back(32'h0000_000A);
        access(1'b0, 11'h000, 32'd0, b1, b2);
        checks++; if (b1 !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL odr_rd_busy got=%b%b exp=10", b1, b2); end
        exp = exp_q.pop_front();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL odr_read got=%h exp=%h", bus.dout, exp); end
    endtask

    task automatic test_unmapped;
        logic        b1, b2;
        logic [31:0] exp;
        logic [10:0] addrs[4] = '{11'h400, 11'h000, 11'h008, 11'h004};
        logic [31:0] exps[4]  = '{32'h0, 32'h0000_000A, 32'h0, 32'h0};
        access(1'b1, 11'h400, 32'hFFFF_FFFF, b1, b2);
        checks++; if (b1 !== 1'b1 || b2 !== 1'b0) begin errors++; $display("FAIL unmapped_wr_busy got=%b%b exp=10", b1, b2); end
        access(1'b1, 11'h408, 32'hFFFF_FFFF, b1, b2);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            access(1'b0, addrs[i], 32'd0, b1, b2);
            exp = exp_q.pop_front();
            checks++;
            if (bus.dout !== exp || b1 !== 1'b1) begin
                errors++;
                $display("FAIL unmapped_read[%0d] got=%h busy=%b exp=%h busy=1", i, bus.dout, b1, exp);
            end
        end
    endtask

    task automatic test_pwm;
        logic b1, b2;
        int   c[4];
        access(1'b1, 11'h00C, 32'h0, b1, b2);
        access(1'b1, 11'h004, 32'h0000_80FF, b1, b2);
        access(1'b1, 11'h008, 32'h3, b1, b2);
        @(posedge clock);
        c = '{0, 0, 0, 0};
        for (int k = 0; k < 256; k++) begin
            @(negedge clock);
            for (int j = 0; j < 4; j++) c[j] += int'(out_leds[j]);
        end
        checks++; if (c[0] != 255) begin errors++; $display("FAIL pwm_led0 got=%0d exp=255", c[0]); end
        checks++; if (c[1] != 128) begin errors++; $display("FAIL pwm_led1 got=%0d exp=128", c[1]); end
        checks++; if (c[2] != 0)   begin errors++; $display("FAIL pwm_led2 got=%0d exp=0", c[2]); end
        checks++; if (c[3] != 256) begin errors++; $display("FAIL pwm_led3 got=%0d exp=256", c[3]); end
        // Tick every second cycle doubles the PWM period.
        access(1'b1, 11'h00C, 32'h1, b1, b2);
        repeat (2) @(posedge clock);
        c = '{0, 0, 0, 0};
        for (int k = 0; k < 512; k++) begin
            @(negedge clock);
            for (int j = 0; j < 2; j++) c[j] += int'(out_leds[j]);
        end
        checks++; if (c[0] != 510) begin errors++; $display("FAIL presc_led0 got=%0d exp=510", c[0]); end
        checks++; if (c[1] != 256) begin errors++; $display("FAIL presc_led1 got=%0d exp=256", c[1]); end
        access(1'b1, 11'h008, 32'h0, b1, b2);
        access(1'b1, 11'h00C, 32'h0, b1, b2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] data[3] = '{32'h3, 32'h5, 32'h6};
        @(negedge clock);
        bus.sel = 1'b1; bus.mem_wr = 1'b1; bus.addr = 11'h000; bus.din = data[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=1", i, bus.busy); end
            if (i > 0) begin
                checks++;
                if (out_leds !== data[i-1][3:0]) begin
                    errors++; $display("FAIL b2b_leds[%0d] got=%b exp=%b", i, out_leds, data[i-1][3:0]);
                end
            end
            @(posedge clock); #1;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got=%b exp=0", i, bus.busy); end
            if (i < 2) bus.din = data[i+1];
            else       bus.sel = 1'b0;
        end
        @(posedge clock); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%b exp=0", bus.busy); end
        checks++; if (out_leds !== 4'h6) begin errors++; $display("FAIL b2b_end_leds got=%b exp=0110", out_leds); end
        // A sel pulse that exists only during ACK must be dropped.
        @(negedge clock);
        bus.sel = 1'b1; bus.din = 32'h9;
        @(posedge clock); #1;
        bus.sel = 1'b0;
        #2;
        bus.sel = 1'b1; bus.din = 32'hC;
        @(posedge clock); #1;
        bus.sel = 1'b0;
        @(posedge clock); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", bus.busy); end
        checks++; if (out_leds !== 4'h9) begin errors++; $display("FAIL drop_leds got=%b exp=1001", out_leds); end
    endtask

    task automatic test_blink;
        logic        b1, b2;
        logic        prev;
        logic [31:0] exp;
        int          n;
        access(1'b1, 11'h000, 32'h1, b1, b2);
        access(1'b1, 11'h008, 32'h10, b1, b2);
`ifdef GPIO_LED_BLINK_EN
        exp_q.push_back(32'h10);
`else
        exp_q.push_back(32'h0);
`endif
        access(1'b0, 11'h008, 32'h0, b1, b2);
        exp = exp_q.pop_front();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL blink_ctrl got=%h exp=%h", bus.dout, exp); end
        @(posedge clock);
`ifdef GPIO_LED_BLINK_EN
        @(negedge clock);
        prev = out_leds[0];
        n = 0;
        while (out_leds[0] === prev && n < 600) begin @(negedge clock); n++; end
        checks++; if (n >= 600) begin errors++; $display("FAIL blink_first got=no_toggle exp=toggle"); end
        for (int t = 0; t < 2; t++) begin
            prev = out_leds[0];
            n = 0;
            while (out_leds[0] === prev && n < 600) begin @(negedge clock); n++; end
            checks++; if (n != 256) begin errors++; $display("FAIL blink_period[%0d] got=%0d exp=256", t, n); end
        end
`else
        prev = 1'b0;
        n = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            n += int'(out_leds[0]);
        end
        checks++; if (n != 600) begin errors++; $display("FAIL noblink_led0 got=%0d exp=600", n); end
`endif
    endtask

    task automatic test_reset_mid_ack;
        logic        b1, b2;
        logic [31:0] exp;
        exp_q.push_back(32'h1);
        access(1'b0, 11'h000, 32'h0, b1, b2);
        exp = exp_q.pop_front();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL pre_rst_read got=%h exp=%h", bus.dout, exp); end
        @(negedge clock);
        bus.sel = 1'b1; bus.mem_wr = 1'b1; bus.addr = 11'h000; bus.din = 32'hF;
        @(posedge clock); #1;
        bus.sel = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midack_busy got=%b exp=1", bus.busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || out_leds !== 4'd0 || bus.dout !== 32'd0) begin
            errors++;
            $display("FAIL midack_reset got=busy%b leds%b dout%h exp=busy0 leds0000 dout0",
                     bus.busy, out_leds, bus.dout);
        end
        @(negedge clock);
        rst = 1'b1;
        exp_q.push_back(32'h0);
        access(1'b0, 11'h000, 32'h0, b1, b2);
        exp = exp_q.pop_front();
        checks++; if (bus.dout !== exp) begin errors++; $display("FAIL midack_odr got=%h exp=%h", bus.dout, exp); end
        @(posedge clock); #1;
        checks++; if (out_leds !== 4'd0) begin errors++; $display("FAIL midack_leds got=%b exp=0000", out_leds); end
    endtask

    initial begin
        test_reset();
        test_odr_rw();
        test_unmapped();
        test_pwm();
        test_back_to_back();
        test_blink();
        test_reset_mid_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
